avl_st_2_avl_st_video: RTL and testbench

- Unpacks a 32-bit byte-packed Avalon-ST stream into a 24-bit-per-pixel Avalon-ST Video stream.
- Each input packet becomes one video packet: a header beat carrying the packet type, followed by one beat per complete 3-byte pixel.
- It is the inverse of the video-to-32-bit packer. It sits on the read side of the frame path, between the 32-bit DMA/FIFO stream and the video pipeline.

---
 rtl/avl_st_video_pkg.sv | 27 ++
 rtl/byte_unpack_buf.sv | 48 ++++
 rtl/avl_st_2_avl_st_video.sv | 123 ++++++++++++
 tb/tb_avl_st_2_avl_st_video.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_st_video_pkg.sv
// Shared types and constants for the 32-bit-to-video unpacking path.
package avl_st_video_pkg;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

    localparam int unsigned BYTES_PER_PIXEL = 3;
    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned PIXEL_W         = 24;
    localparam int unsigned BUF_W           = 64;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               sop;
        logic               eop;
        logic [PIXEL_W-1:0] data;
    } video_beat_t;

endpackage

// File: rtl/byte_unpack_buf.sv
// 8-byte little-endian staging buffer: push appends a word above the fill
// level, pop drops the lowest pixel, clear empties it.
module byte_unpack_buf
    import avl_st_video_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WORD_W-1:0]  push_data,
    input  logic               pop,
    input  logic               clear,
    output logic [PIXEL_W-1:0] head,
    output logic [CNT_W-1:0]   byte_cnt
);

    logic [BUF_W-1:0] data_q;
    logic [BUF_W-1:0] data_d;
    logic [CNT_W-1:0] cnt_pop;
    logic [CNT_W-1:0] cnt_d;

    // Pop happens before push so a same-cycle word lands just above the remainder.
    always_comb begin
        data_d  = pop ? (data_q >> (BYTES_PER_PIXEL * 8)) : data_q;
        cnt_pop = pop ? (byte_cnt - CNT_W'(BYTES_PER_PIXEL)) : byte_cnt;
        cnt_d   = cnt_pop;
        if (push) begin
            data_d = data_d | ({{(BUF_W-WORD_W){1'b0}}, push_data} << {cnt_pop, 3'b000});
            cnt_d  = cnt_pop + CNT_W'(BYTES_PER_WORD);
        end
        if (clear) begin
            data_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            byte_cnt <= '0;
        end else begin
            data_q   <= data_d;
            byte_cnt <= cnt_d;
        end
    end

    assign head = data_q[PIXEL_W-1:0];

endmodule

// File: rtl/avl_st_2_avl_st_video.sv
// Unpacks a byte-packed 32-bit Avalon-ST stream into 24-bit Avalon-ST Video
// packets (optional header beat, then one beat per complete pixel).
module avl_st_2_avl_st_video
    import avl_st_video_pkg::*;
#(
    parameter logic [3:0] PACKET_TYPE = PKT_TYPE_VIDEO,
    parameter bit         HEADER_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WORD_W-1:0]  in_avl_st_data,
    input  logic               in_avl_st_valid,
    input  logic               in_avl_st_startofpacket,
    input  logic               in_avl_st_endofpacket,
    output logic               in_avl_st_ready,
    output logic [PIXEL_W-1:0] out_avl_st_data,
    output logic               out_avl_st_valid,
    output logic               out_avl_st_startofpacket,
    output logic               out_avl_st_endofpacket,
    input  logic               out_avl_st_ready,
    output logic               protocol_error
);

    state_t           state;
    video_beat_t      out_q;
    logic             first_pix;
    logic             eof_pending;
    logic             accept;
    logic             load;
    logic             has_pix;
    logic             last_pix;
    logic             push;
    logic             pop;
    logic             clear;
    logic [PIXEL_W-1:0] head;
    logic [CNT_W-1:0] byte_cnt;

    byte_unpack_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_avl_st_data),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .byte_cnt  (byte_cnt)
    );

    // Handshake and buffer control; the eop pixel empties the buffer instead of popping.
    always_comb begin
        in_avl_st_ready = (byte_cnt <= CNT_W'(BYTES_PER_WORD)) && !eof_pending
                          && ((state != HEADER) || !HEADER_EN);
        accept   = in_avl_st_valid && in_avl_st_ready;
        load     = !out_q.valid || out_avl_st_ready;
        has_pix  = byte_cnt >= CNT_W'(BYTES_PER_PIXEL);
        last_pix = eof_pending && (byte_cnt < CNT_W'(2 * BYTES_PER_PIXEL));
        push     = accept && ((state == DATA) || ((state == IDLE) && in_avl_st_startofpacket));
        pop      = (state == DATA) && load && has_pix && !last_pix;
        clear    = (state == DATA) && load && has_pix && last_pix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            out_q          <= '0;
            first_pix      <= 1'b0;
            eof_pending    <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            protocol_error <= 1'b0;
            if (load) begin
                out_q.valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_avl_st_startofpacket) begin
                            state       <= HEADER_EN ? HEADER : DATA;
                            first_pix   <= !HEADER_EN;
                            eof_pending <= in_avl_st_endofpacket;
                        end else begin
                            protocol_error <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (load) begin
                        out_q <= '{valid: 1'b1, sop: 1'b1, eop: 1'b0,
                                   data: {20'h0, PACKET_TYPE}};
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (in_avl_st_startofpacket) begin
                            protocol_error <= 1'b1;
                        end
                        if (in_avl_st_endofpacket) begin
                            eof_pending <= 1'b1;
                        end
                    end
                    // Earliest byte goes to the most significant pixel lane.
                    if (load && has_pix) begin
                        out_q <= '{valid: 1'b1, sop: first_pix, eop: last_pix,
                                   data: {head[7:0], head[15:8], head[23:16]}};
                        first_pix <= 1'b0;
                        if (last_pix) begin
                            eof_pending <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_avl_st_data          = out_q.data;
    assign out_avl_st_valid         = out_q.valid;
    assign out_avl_st_startofpacket = out_q.sop;
    assign out_avl_st_endofpacket   = out_q.eop;

endmodule

// File: tb/tb_avl_st_2_avl_st_video.sv
// Randomised self-checking bench for the 32-bit to video unpacker (header and no-header builds).
module tb_avl_st_2_avl_st_video;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic        out_ready;
    logic        sel;
    logic        bp_mode;

    logic        a_in_valid, b_in_valid;
    logic        a_in_ready, b_in_ready;
    logic [23:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid, a_out_sop, b_out_sop, a_out_eop, b_out_eop;
    logic        a_perr, b_perr;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    perr_a = 0;
    int    perr_b = 0;
    beat_t got_a[$];
    beat_t got_b[$];

    always #5 clk = ~clk;

    assign a_in_valid = in_valid && !sel;
    assign b_in_valid = in_valid && sel;

    avl_st_2_avl_st_video #(.PACKET_TYPE(4'h0), .HEADER_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_avl_st_data(in_data), .in_avl_st_valid(a_in_valid),
        .in_avl_st_startofpacket(in_sop), .in_avl_st_endofpacket(in_eop),
        .in_avl_st_ready(a_in_ready),
        .out_avl_st_data(a_out_data), .out_avl_st_valid(a_out_valid),
        .out_avl_st_startofpacket(a_out_sop), .out_avl_st_endofpacket(a_out_eop),
        .out_avl_st_ready(out_ready), .protocol_error(a_perr)
    );

    avl_st_2_avl_st_video #(.PACKET_TYPE(4'hA), .HEADER_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_avl_st_data(in_data), .in_avl_st_valid(b_in_valid),
        .in_avl_st_startofpacket(in_sop), .in_avl_st_endofpacket(in_eop),
        .in_avl_st_ready(b_in_ready),
        .out_avl_st_data(b_out_data), .out_avl_st_valid(b_out_valid),
        .out_avl_st_startofpacket(b_out_sop), .out_avl_st_endofpacket(b_out_eop),
        .out_avl_st_ready(out_ready), .protocol_error(b_perr)
    );

    // Downstream ready: constant 1, or toggling every cycle in back-pressure mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = ~out_ready;
            else         out_ready = 1'b1;
        end
    end

    // Output monitor: collects accepted beats, counts error pulses, checks hold-while-stalled.
    initial begin
        beat_t pa;
        logic  pv, pr, prev_rst;
        pv = 1'b0; pr = 1'b0; prev_rst = 1'b0;
        pa = '{data: 24'h0, sop: 1'b0, eop: 1'b0};
        forever begin
            @(negedge clk);
            if (rst_n && prev_rst && pv && !pr) begin
                n_cmp++;
                if (a_out_valid !== 1'b1 || a_out_data !== pa.data ||
                    a_out_sop !== pa.sop || a_out_eop !== pa.eop) begin
                    n_bad++;
                    $display("FAIL hold_stable: got v=%b d=%h sop=%b eop=%b, need v=1 d=%h sop=%b eop=%b",
                             a_out_valid, a_out_data, a_out_sop, a_out_eop, pa.data, pa.sop, pa.eop);
                end
            end
            if (rst_n) begin
                n_cmp++;
                if (a_in_ready && dut_a.u_buf.byte_cnt > 4'd4) begin
                    n_bad++;
                    $display("FAIL ready_vs_fill: got in_ready=1 with byte_cnt=%0d, need byte_cnt<=4",
                             dut_a.u_buf.byte_cnt);
                end
                if (a_out_valid && out_ready) got_a.push_back('{data: a_out_data, sop: a_out_sop, eop: a_out_eop});
                if (b_out_valid && out_ready) got_b.push_back('{data: b_out_data, sop: b_out_sop, eop: b_out_eop});
                if (a_perr) perr_a++;
                if (b_perr) perr_b++;
            end
            pv = a_out_valid; pr = out_ready; prev_rst = rst_n;
            pa = '{data: a_out_data, sop: a_out_sop, eop: a_out_eop};
        end
    end

    // Reference: concatenate bytes in stream order, cut into 3-byte pixels, drop residue.
    function automatic void model(input logic [31:0] w[$], input bit hdr, input logic [3:0] pt,
                                  output beat_t e[$]);
        logic [7:0] b[$];
        int np;
        e = {};
        foreach (w[i]) for (int k = 0; k < 4; k++) b.push_back(w[i][8*k +: 8]);
        if (hdr) e.push_back('{data: {20'h0, pt}, sop: 1'b1, eop: 1'b0});
        np = b.size() / 3;
        for (int p = 0; p < np; p++)
            e.push_back('{data: {b[3*p], b[3*p+1], b[3*p+2]}, sop: (!hdr && p == 0), eop: (p == np - 1)});
    endfunction

    function automatic void rand_words(input int n, output logic [31:0] w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endfunction

    task automatic send_words(input logic [31:0] w[$], input bit sop_first, input bit eop_last, input int gap);
        bit done;
        int t;
        for (int i = 0; i < w.size(); i++) begin
            done = 1'b0;
            t = 0;
            while (!done) begin
                in_data  = w[i];
                in_sop   = sop_first && (i == 0);
                in_eop   = eop_last && (i == w.size() - 1);
                in_valid = (int'($urandom_range(99)) >= gap);
                @(negedge clk);
                done = in_valid && (sel ? b_in_ready : a_in_ready);
                @(posedge clk);
                #1;
                t++;
                if (!done && t > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL send_timeout: word %0d got in_ready=0 for 200 cycles, need 1", i);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic check_beats(input string name, input beat_t e[$], input bit use_b);
        beat_t g[$];
        int t;
        t = 0;
        while (((use_b ? got_b.size() : got_a.size()) < e.size()) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        repeat (8) @(posedge clk);
        #1;
        g = use_b ? got_b : got_a;
        n_cmp++;
        if (g.size() != e.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d beats, need %0d", name, g.size(), e.size());
        end
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            n_cmp++;
            if (g[i].data !== e[i].data || g[i].sop !== e[i].sop || g[i].eop !== e[i].eop) begin
                n_bad++;
                $display("FAIL %s_beat%0d: got d=%h sop=%b eop=%b, need d=%h sop=%b eop=%b",
                         name, i, g[i].data, g[i].sop, g[i].eop, e[i].data, e[i].sop, e[i].eop);
            end
        end
        got_a = {};
        got_b = {};
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_out_data !== 24'h0 || a_out_sop !== 1'b0 ||
            a_out_eop !== 1'b0 || a_perr !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_a: got v=%b d=%h sop=%b eop=%b perr=%b, need all 0",
                     name, a_out_valid, a_out_data, a_out_sop, a_out_eop, a_perr);
        end
        n_cmp++;
        if (b_out_valid !== 1'b0 || b_out_data !== 24'h0 || b_out_sop !== 1'b0 ||
            b_out_eop !== 1'b0 || b_perr !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_b: got v=%b d=%h sop=%b eop=%b perr=%b, need all 0",
                     name, b_out_valid, b_out_data, b_out_sop, b_out_eop, b_perr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, need 1", a_in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] w[$];
        beat_t e[$];
        w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        model(w, 1'b1, 4'h0, e);
        n_cmp++;
        if (e[1].data !== 24'h112233 || e[4].data !== 24'hAABBCC) begin
            n_bad++;
            $display("FAIL model_sanity: got %h/%h, need 112233/aabbcc", e[1].data, e[4].data);
        end
        send_words(w, 1'b1, 1'b1, 0);
        check_beats("basic", e, 1'b0);
    endtask

    task automatic test_two_word();
        logic [31:0] w[$];
        beat_t e[$];
        w = '{32'h44332211, 32'h88776655};
        model(w, 1'b1, 4'h0, e);
        send_words(w, 1'b1, 1'b1, 0);
        check_beats("two_word", e, 1'b0);
        rand_words(3, w);
        model(w, 1'b1, 4'h0, e);
        send_words(w, 1'b1, 1'b1, 0);
        check_beats("after_two_word", e, 1'b0);
    endtask

    task automatic test_back_to_back_bp();
        logic [31:0] w[$];
        beat_t e[$];
        bp_mode = 1'b1;
        w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        model(w, 1'b1, 4'h0, e);
        send_words(w, 1'b1, 1'b1, 50);
        check_beats("bp_directed", e, 1'b0);
        for (int p = 0; p < 6; p++) begin
            rand_words(int'($urandom_range(1, 6)), w);
            model(w, 1'b1, 4'h0, e);
            send_words(w, 1'b1, 1'b1, 40);
            check_beats("bp_random", e, 1'b0);
        end
        bp_mode = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_protocol_error();
        logic [31:0] w[$];
        beat_t e[$];
        int p0;
        p0 = perr_a;
        w = '{32'hDEADBEEF};
        send_words(w, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (perr_a - p0 != 1) begin
            n_bad++;
            $display("FAIL perr_pulses: got %0d, need 1", perr_a - p0);
        end
        n_cmp++;
        if (got_a.size() != 0) begin
            n_bad++;
            $display("FAIL perr_no_output: got %0d beats, need 0", got_a.size());
        end
        rand_words(4, w);
        model(w, 1'b1, 4'h0, e);
        send_words(w, 1'b1, 1'b1, 20);
        check_beats("after_perr", e, 1'b0);
    endtask

    task automatic test_no_header();
        logic [31:0] w[$];
        beat_t e[$];
        sel = 1'b1;
        w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        model(w, 1'b0, 4'hA, e);
        n_cmp++;
        if (e.size() != 4 || e[0].sop !== 1'b1 || e[0].data !== 24'h112233) begin
            n_bad++;
            $display("FAIL model_nohdr: got %0d beats first=%h, need 4 beats first=112233", e.size(), e[0].data);
        end
        send_words(w, 1'b1, 1'b1, 0);
        check_beats("no_header", e, 1'b1);
        for (int p = 0; p < 3; p++) begin
            rand_words(int'($urandom_range(1, 5)), w);
            model(w, 1'b0, 4'hA, e);
            send_words(w, 1'b1, 1'b1, 30);
            check_beats("no_header_rand", e, 1'b1);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        beat_t e[$];
        w = '{32'h44332211, 32'h88776655};
        send_words(w, 1'b1, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero_outputs("mid_reset");
        rst_n = 1'b1;
        got_a = {};
        got_b = {};
        @(posedge clk); #1;
        w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        model(w, 1'b1, 4'h0, e);
        send_words(w, 1'b1, 1'b1, 0);
        check_beats("after_mid_reset", e, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_data = 32'h0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        sel = 1'b0; bp_mode = 1'b0; rst_n = 1'b0;
        test_reset();
        test_basic();
        test_two_word();
        test_back_to_back_bp();
        test_protocol_error();
        test_no_header();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
